// File: rtl/l2tlb_ctx.sv
// L2-side TLB translation array: fully-associative VPN->PPN entries tagged by a
// small SBPTR context table, with lookup, fill, checkpoint-create flush and L1 flush notify.
module l2tlb_ctx #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned NUM_CTX = 4,
  parameter int unsigned SBPTR_W = 12,
  parameter int unsigned VPN_W   = 38,
  parameter int unsigned PPN_W   = 38
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lookup_valid,
  output logic               lookup_retry,
  input  logic [SBPTR_W-1:0] lookup_sbptr,
  input  logic [VPN_W-1:0]   lookup_vpn,
  output logic               resp_valid,
  input  logic               resp_retry,
  output logic               resp_hit,
  output logic [PPN_W-1:0]   resp_ppn,
  input  logic               fill_valid,
  output logic               fill_retry,
  input  logic [SBPTR_W-1:0] fill_sbptr,
  input  logic [VPN_W-1:0]   fill_vpn,
  input  logic [PPN_W-1:0]   fill_ppn,
  input  logic               create_valid,
  output logic               create_retry,
  input  logic [SBPTR_W-1:0] create_sbptr,
  output logic               inval_valid,
  input  logic               inval_retry,
  output logic [SBPTR_W-1:0] inval_sbptr
);

  localparam int unsigned EI_W = $clog2(ENTRIES);
  localparam int unsigned CI_W = $clog2(NUM_CTX);

  logic [ENTRIES-1:0] ent_valid;
  logic [CI_W-1:0]    ent_ctx [ENTRIES];
  logic [VPN_W-1:0]   ent_vpn [ENTRIES];
  logic [PPN_W-1:0]   ent_ppn [ENTRIES];
  logic [EI_W-1:0]    ent_rr;

  logic [NUM_CTX-1:0] ctx_valid;
  logic [SBPTR_W-1:0] ctx_sbptr [NUM_CTX];
  logic [CI_W-1:0]    ctx_rr;

  logic               lk_ctx_hit;
  logic [CI_W-1:0]    lk_ctx;
  logic               lk_hit;
  logic [PPN_W-1:0]   lk_ppn;

  logic [SBPTR_W-1:0] op_sbptr;
  logic               op_hit;
  logic [CI_W-1:0]    op_idx;
  logic               free_any;
  logic [CI_W-1:0]    free_idx;
  logic               alloc_evict;
  logic [CI_W-1:0]    slot;

  logic               notify_busy;
  logic               create_go;
  logic               fill_go;
  logic               lookup_go;
  logic               op_go;
  logic               clear_ctx;
  logic               ctx_alloc;
  logic [SBPTR_W-1:0] notify_sbptr;

  logic [ENTRIES-1:0] clear_mask;
  logic [ENTRIES-1:0] eff_valid;
  logic [ENTRIES-1:0] ent_valid_nxt;
  logic               ent_hit;
  logic [EI_W-1:0]    ent_hit_idx;
  logic               ent_free;
  logic [EI_W-1:0]    ent_free_idx;
  logic [EI_W-1:0]    wr_idx;
  logic               rr_inc;

  // Lookup path reads the current array state
  always_comb begin
    lk_ctx_hit = 1'b0;
    lk_ctx     = '0;
    lk_hit     = 1'b0;
    lk_ppn     = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      if (ctx_valid[c] && ctx_sbptr[c] == lookup_sbptr) begin
        lk_ctx_hit = 1'b1;
        lk_ctx     = CI_W'(c);
      end
    end
    for (int e = 0; e < ENTRIES; e++) begin
      if (lk_ctx_hit && ent_valid[e] && ent_ctx[e] == lk_ctx && ent_vpn[e] == lookup_vpn) begin
        lk_hit = 1'b1;
        lk_ppn = ent_ppn[e];
      end
    end
  end

  // Context resolution for the fill/create op; descending scan yields lowest free slot
  always_comb begin
    op_sbptr = create_valid ? create_sbptr : fill_sbptr;
    op_hit   = 1'b0;
    op_idx   = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int c = NUM_CTX - 1; c >= 0; c--) begin
      if (ctx_valid[c] && ctx_sbptr[c] == op_sbptr) begin
        op_hit = 1'b1;
        op_idx = CI_W'(c);
      end
      if (!ctx_valid[c]) begin
        free_any = 1'b1;
        free_idx = CI_W'(c);
      end
    end
    alloc_evict = !op_hit && !free_any;
    slot        = op_hit ? op_idx : (free_any ? free_idx : ctx_rr);
  end

  assign notify_busy  = inval_valid & inval_retry;
  assign create_retry = notify_busy;
  assign fill_retry   = create_valid | (notify_busy & alloc_evict);
  assign lookup_retry = (resp_valid & resp_retry) | create_valid | fill_valid;

  assign create_go = create_valid & ~create_retry;
  assign fill_go   = fill_valid & ~fill_retry;
  assign lookup_go = lookup_valid & ~lookup_retry;
  assign op_go     = create_go | fill_go;

  // A slot is flushed either by create of a present context or by eviction
  assign clear_ctx    = (create_go & op_hit) | (op_go & alloc_evict);
  assign ctx_alloc    = op_go & ~op_hit;
  assign notify_sbptr = op_hit ? create_sbptr : ctx_sbptr[ctx_rr];

  // Entry victim selection sees the array after any same-cycle flush
  always_comb begin
    clear_mask   = '0;
    ent_hit      = 1'b0;
    ent_hit_idx  = '0;
    ent_free     = 1'b0;
    ent_free_idx = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      clear_mask[e] = clear_ctx && ent_valid[e] && ent_ctx[e] == slot;
    end
    eff_valid = ent_valid & ~clear_mask;
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      if (eff_valid[e] && ent_ctx[e] == slot && ent_vpn[e] == fill_vpn) begin
        ent_hit     = 1'b1;
        ent_hit_idx = EI_W'(e);
      end
      if (!eff_valid[e]) begin
        ent_free     = 1'b1;
        ent_free_idx = EI_W'(e);
      end
    end
    wr_idx        = ent_hit ? ent_hit_idx : (ent_free ? ent_free_idx : ent_rr);
    rr_inc        = fill_go && !ent_hit && !ent_free;
    ent_valid_nxt = eff_valid;
    if (fill_go) begin
      ent_valid_nxt[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_valid   <= '0;
      ctx_valid   <= '0;
      ent_rr      <= '0;
      ctx_rr      <= '0;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_ppn    <= '0;
      inval_valid <= 1'b0;
      inval_sbptr <= '0;
    end else begin
      ent_valid <= ent_valid_nxt;
      if (ctx_alloc) begin
        ctx_valid[slot] <= 1'b1;
      end
      if (ctx_alloc && alloc_evict) begin
        ctx_rr <= ctx_rr + 1'b1;
      end
      if (rr_inc) begin
        ent_rr <= ent_rr + 1'b1;
      end
      if (lookup_go) begin
        resp_valid <= 1'b1;
        resp_hit   <= lk_hit;
        resp_ppn   <= lk_ppn;
      end else if (!resp_retry) begin
        resp_valid <= 1'b0;
      end
      if (clear_ctx) begin
        inval_valid <= 1'b1;
        inval_sbptr <= notify_sbptr;
      end else if (!inval_retry) begin
        inval_valid <= 1'b0;
      end
    end
  end

  // Payload storage; qualified by the valid bits so it needs no reset
  always_ff @(posedge clk) begin
    if (fill_go) begin
      ent_ctx[wr_idx] <= slot;
      ent_vpn[wr_idx] <= fill_vpn;
      ent_ppn[wr_idx] <= fill_ppn;
    end
    if (ctx_alloc) begin
      ctx_sbptr[slot] <= op_sbptr;
    end
  end

endmodule

// File: tb/tb_l2tlb_ctx.sv
// Directed bench for l2tlb_ctx: vector table of fill/lookup/create/reset ops plus
// hand sequences for response hold, notify backpressure and op priority.
module tb_l2tlb_ctx;
  localparam int unsigned SW = 12;
  localparam int unsigned VW = 38;
  localparam int unsigned PW = 38;

  logic          clk = 1'b0;
  logic          reset;
  logic          lookup_valid, lookup_retry;
  logic [SW-1:0] lookup_sbptr;
  logic [VW-1:0] lookup_vpn;
  logic          resp_valid, resp_retry, resp_hit;
  logic [PW-1:0] resp_ppn;
  logic          fill_valid, fill_retry;
  logic [SW-1:0] fill_sbptr;
  logic [VW-1:0] fill_vpn;
  logic [PW-1:0] fill_ppn;
  logic          create_valid, create_retry;
  logic [SW-1:0] create_sbptr;
  logic          inval_valid, inval_retry;
  logic [SW-1:0] inval_sbptr;

  always #5 clk = ~clk;

  l2tlb_ctx #(.ENTRIES(16), .NUM_CTX(4), .SBPTR_W(SW), .VPN_W(VW), .PPN_W(PW)) dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_retry(lookup_retry),
    .lookup_sbptr(lookup_sbptr), .lookup_vpn(lookup_vpn),
    .resp_valid(resp_valid), .resp_retry(resp_retry), .resp_hit(resp_hit), .resp_ppn(resp_ppn),
    .fill_valid(fill_valid), .fill_retry(fill_retry), .fill_sbptr(fill_sbptr),
    .fill_vpn(fill_vpn), .fill_ppn(fill_ppn),
    .create_valid(create_valid), .create_retry(create_retry), .create_sbptr(create_sbptr),
    .inval_valid(inval_valid), .inval_retry(inval_retry), .inval_sbptr(inval_sbptr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef enum int {K_RST, K_FILL, K_LOOK, K_CREATE} kind_e;

  typedef struct {
    kind_e         kind;
    logic [SW-1:0] sb;
    logic [VW-1:0] vpn;
    logic [PW-1:0] ppn;
    logic          hit;
    logic [PW-1:0] eppn;
    logic          inv;
    logic [SW-1:0] isb;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(kind_e k, logic [SW-1:0] sb, logic [VW-1:0] vpn, logic [PW-1:0] ppn,
                              logic hit, logic [PW-1:0] eppn, logic inv, logic [SW-1:0] isb);
    vec_t v;
    v.kind = k; v.sb = sb; v.vpn = vpn; v.ppn = ppn;
    v.hit = hit; v.eppn = eppn; v.inv = inv; v.isb = isb;
    return v;
  endfunction

  function automatic void add_fill(logic [SW-1:0] sb, logic [VW-1:0] vpn, logic [PW-1:0] ppn,
                                   logic inv, logic [SW-1:0] isb);
    vq.push_back(mk(K_FILL, sb, vpn, ppn, 1'b0, '0, inv, isb));
  endfunction

  function automatic void add_look(logic [SW-1:0] sb, logic [VW-1:0] vpn, logic hit, logic [PW-1:0] eppn);
    vq.push_back(mk(K_LOOK, sb, vpn, '0, hit, eppn, 1'b0, '0));
  endfunction

  function automatic void add_create(logic [SW-1:0] sb, logic inv, logic [SW-1:0] isb);
    vq.push_back(mk(K_CREATE, sb, '0, '0, 1'b0, '0, inv, isb));
  endfunction

  function automatic void add_rst();
    vq.push_back(mk(K_RST, '0, '0, '0, 1'b0, '0, 1'b0, '0));
  endfunction

  task automatic apply(input vec_t v, input string tag);
    case (v.kind)
      K_RST: begin
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk({tag, " rst resp_valid"}, 64'(resp_valid), 64'(0));
        chk({tag, " rst resp_hit"}, 64'(resp_hit), 64'(0));
        chk({tag, " rst resp_ppn"}, 64'(resp_ppn), 64'(0));
        chk({tag, " rst inval_valid"}, 64'(inval_valid), 64'(0));
        chk({tag, " rst inval_sbptr"}, 64'(inval_sbptr), 64'(0));
        @(negedge clk);
        reset = 1'b1;
      end
      K_FILL: begin
        @(negedge clk);
        fill_valid = 1'b1; fill_sbptr = v.sb; fill_vpn = v.vpn; fill_ppn = v.ppn;
        #1 chk({tag, " fill_retry"}, 64'(fill_retry), 64'(0));
        @(posedge clk);
        #1 fill_valid = 1'b0;
      end
      K_LOOK: begin
        @(negedge clk);
        lookup_valid = 1'b1; lookup_sbptr = v.sb; lookup_vpn = v.vpn;
        #1 chk({tag, " lookup_retry"}, 64'(lookup_retry), 64'(0));
        @(posedge clk);
        #1 lookup_valid = 1'b0;
        chk({tag, " resp_valid"}, 64'(resp_valid), 64'(1));
        chk({tag, " resp_hit"}, 64'(resp_hit), 64'(v.hit));
        chk({tag, " resp_ppn"}, 64'(resp_ppn), 64'(v.eppn));
      end
      K_CREATE: begin
        @(negedge clk);
        create_valid = 1'b1; create_sbptr = v.sb;
        #1 chk({tag, " create_retry"}, 64'(create_retry), 64'(0));
        @(posedge clk);
        #1 create_valid = 1'b0;
      end
      default: ;
    endcase
    if (v.kind != K_RST) begin
      chk({tag, " inval_valid"}, 64'(inval_valid), 64'(v.inv));
      if (v.inv) chk({tag, " inval_sbptr"}, 64'(inval_sbptr), 64'(v.isb));
    end
  endtask

  initial begin
    reset = 1'b0;
    lookup_valid = 1'b0; lookup_sbptr = '0; lookup_vpn = '0;
    resp_retry = 1'b0;
    fill_valid = 1'b0; fill_sbptr = '0; fill_vpn = '0; fill_ppn = '0;
    create_valid = 1'b0; create_sbptr = '0;
    inval_retry = 1'b0;

    // Basic hit/miss, in-place overwrite, create flush, context eviction
    add_rst();
    add_fill(12'h010, 38'h5, 38'h99, 1'b0, '0);
    add_look(12'h010, 38'h5, 1'b1, 38'h99);
    add_look(12'h010, 38'h6, 1'b0, 38'h0);
    add_look(12'h011, 38'h5, 1'b0, 38'h0);
    add_fill(12'h010, 38'h5, 38'hAA, 1'b0, '0);
    add_look(12'h010, 38'h5, 1'b1, 38'hAA);
    add_fill(12'h020, 38'h7, 38'h77, 1'b0, '0);
    add_look(12'h020, 38'h7, 1'b1, 38'h77);
    add_look(12'h020, 38'h5, 1'b0, 38'h0);
    add_look(12'h010, 38'h7, 1'b0, 38'h0);
    add_create(12'h010, 1'b1, 12'h010);
    add_look(12'h010, 38'h5, 1'b0, 38'h0);
    add_look(12'h020, 38'h7, 1'b1, 38'h77);
    add_create(12'h030, 1'b0, '0);
    add_fill(12'h030, 38'h1, 38'h11, 1'b0, '0);
    add_look(12'h030, 38'h1, 1'b1, 38'h11);
    add_fill(12'h040, 38'h2, 38'h22, 1'b0, '0);
    add_fill(12'h050, 38'h3, 38'h33, 1'b1, 12'h010);
    add_look(12'h050, 38'h3, 1'b1, 38'h33);
    add_fill(12'h060, 38'h4, 38'h44, 1'b1, 12'h020);
    add_look(12'h020, 38'h7, 1'b0, 38'h0);
    add_look(12'h060, 38'h4, 1'b1, 38'h44);
    add_look(12'h030, 38'h1, 1'b1, 38'h11);
    // Entry round-robin replacement once the array is full
    add_rst();
    for (int i = 0; i < 16; i++) add_fill(12'h100, 38'(38'h100 + i), 38'(38'h200 + i), 1'b0, '0);
    add_fill(12'h100, 38'h110, 38'h210, 1'b0, '0);
    add_look(12'h100, 38'h100, 1'b0, 38'h0);
    add_look(12'h100, 38'h110, 1'b1, 38'h210);
    add_look(12'h100, 38'h101, 1'b1, 38'h201);
    add_fill(12'h100, 38'h111, 38'h211, 1'b0, '0);
    add_look(12'h100, 38'h101, 1'b0, 38'h0);
    add_look(12'h100, 38'h111, 1'b1, 38'h211);
    add_look(12'h100, 38'h102, 1'b1, 38'h202);
    add_look(12'h100, 38'h10F, 1'b1, 38'h20F);
    // Fifth context evicts the first
    add_rst();
    for (int i = 0; i < 4; i++) add_fill(12'(12'h0A0 + i), 38'(38'h30 + i), 38'(38'h40 + i), 1'b0, '0);
    add_fill(12'h0A4, 38'h34, 38'h44, 1'b1, 12'h0A0);
    add_look(12'h0A0, 38'h30, 1'b0, 38'h0);
    add_look(12'h0A4, 38'h34, 1'b1, 38'h44);
    add_look(12'h0A1, 38'h31, 1'b1, 38'h41);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("v%0d", i));

    // Response held under resp_retry, lookup stalled meanwhile
    apply(mk(K_RST, '0, '0, '0, 1'b0, '0, 1'b0, '0), "h1");
    apply(mk(K_FILL, 12'h010, 38'h5, 38'h99, 1'b0, '0, 1'b0, '0), "h1");
    @(negedge clk);
    lookup_valid = 1'b1; lookup_sbptr = 12'h010; lookup_vpn = 38'h5; resp_retry = 1'b1;
    #1 chk("hold first lookup_retry", 64'(lookup_retry), 64'(0));
    @(posedge clk);
    #1 lookup_vpn = 38'h6;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d lookup_retry", k), 64'(lookup_retry), 64'(1));
      chk($sformatf("hold%0d resp_valid", k), 64'(resp_valid), 64'(1));
      chk($sformatf("hold%0d resp_hit", k), 64'(resp_hit), 64'(1));
      chk($sformatf("hold%0d resp_ppn", k), 64'(resp_ppn), 64'(38'h99));
    end
    @(negedge clk);
    resp_retry = 1'b0;
    #1 chk("release lookup_retry", 64'(lookup_retry), 64'(0));
    @(posedge clk);
    #1 lookup_valid = 1'b0;
    chk("release resp_valid", 64'(resp_valid), 64'(1));
    chk("release resp_hit", 64'(resp_hit), 64'(0));
    chk("release resp_ppn", 64'(resp_ppn), 64'(0));
    @(posedge clk);
    #1 chk("drained resp_valid", 64'(resp_valid), 64'(0));

    // Notify backpressure blocks a second create until it drains
    @(negedge clk);
    inval_retry = 1'b1; create_valid = 1'b1; create_sbptr = 12'h010;
    #1 chk("nb create1 retry", 64'(create_retry), 64'(0));
    @(posedge clk);
    #1 create_valid = 1'b0;
    chk("nb inval_valid", 64'(inval_valid), 64'(1));
    chk("nb inval_sbptr", 64'(inval_sbptr), 64'(12'h010));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      create_valid = 1'b1; create_sbptr = 12'h020;
      #1 chk($sformatf("nb%0d create_retry", k), 64'(create_retry), 64'(1));
      chk($sformatf("nb%0d inval_valid", k), 64'(inval_valid), 64'(1));
      chk($sformatf("nb%0d inval_sbptr", k), 64'(inval_sbptr), 64'(12'h010));
    end
    @(negedge clk);
    inval_retry = 1'b0;
    #1 chk("nb drain create_retry", 64'(create_retry), 64'(0));
    @(posedge clk);
    #1 create_valid = 1'b0;
    chk("nb drained inval_valid", 64'(inval_valid), 64'(0));
    apply(mk(K_LOOK, 12'h010, 38'h5, '0, 1'b0, 38'h0, 1'b0, '0), "nb flushed");

    // Create beats fill beats lookup
    @(negedge clk);
    create_valid = 1'b1; create_sbptr = 12'h030;
    fill_valid = 1'b1; fill_sbptr = 12'h010; fill_vpn = 38'h8; fill_ppn = 38'h88;
    lookup_valid = 1'b1; lookup_sbptr = 12'h010; lookup_vpn = 38'h5;
    #1 chk("prio create_retry", 64'(create_retry), 64'(0));
    chk("prio fill_retry", 64'(fill_retry), 64'(1));
    chk("prio lookup_retry", 64'(lookup_retry), 64'(1));
    @(posedge clk);
    #1 create_valid = 1'b0; fill_valid = 1'b0; lookup_valid = 1'b0;
    chk("prio resp_valid", 64'(resp_valid), 64'(0));
    chk("prio inval_valid", 64'(inval_valid), 64'(0));
    apply(mk(K_LOOK, 12'h010, 38'h8, '0, 1'b0, 38'h0, 1'b0, '0), "prio fill dropped");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/l2tlb_ctx.md
Name: l2tlb_ctx

Overview:
Parametrised translation array for the L2-side TLB, successor to the empty L2TLB shell. It holds ENTRIES fully-associative VPN->PPN translations tagged by a small context table of NUM_CTX SBPTR slots. It also services lookups, fills and SBPTR checkpoint-create flushes, and notifies L1 of every context flush over a valid/retry channel. All channels use the codebase valid/retry handshake: a transfer occurs when valid=1 and retry=0.

Parameters:
ENTRIES, 16, number of translation entries (power of 2, >=2)
NUM_CTX, 4, number of tracked SBPTR contexts (power of 2, >=2)
SBPTR_W, 12, SBPTR width
VPN_W, 38, virtual page number width
PPN_W, 38, physical page number width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
lookup_valid  in  1  lookup request
lookup_retry  out  1  lookup stall
lookup_sbptr  in  SBPTR_W  lookup context
lookup_vpn  in  VPN_W  lookup page
resp_valid  out  1  lookup response
resp_retry  in  1  response stall
resp_hit  out  1  1 = translation found
resp_ppn  out  PPN_W  translated page (0 on miss)
fill_valid  in  1  install translation
fill_retry  out  1  fill stall
fill_sbptr  in  SBPTR_W  fill context
fill_vpn  in  VPN_W  fill page
fill_ppn  in  PPN_W  fill translation
create_valid  in  1  SBPTR checkpoint create
create_retry  out  1  create stall
create_sbptr  in  SBPTR_W  created SBPTR
inval_valid  out  1  L1 flush notify
inval_retry  in  1  notify stall
inval_sbptr  out  SBPTR_W  flushed SBPTR

Behaviour:
- Reset (reset=0, async): all entry and context valid bits 0; entry RR pointer and ctx RR pointer 0; resp_valid=0, resp_hit=0, resp_ppn=0, inval_valid=0, inval_sbptr=0.
- Only one operation is accepted per cycle. Priority: create > fill > lookup. A losing request sees retry=1 that cycle.
- notify_busy = inval_valid & inval_retry. While notify_busy=1, create_retry=1, and fill_retry=1 if the fill needs a context eviction.
- lookup_retry = resp_valid & resp_retry, or a higher-priority op is valid.
- Lookup: context match = valid slot with equal sbptr. Hit = valid entry with matching ctx index and vpn. Response is registered with 1-cycle latency. resp_valid, resp_hit and resp_ppn are held stable while resp_retry=1. An unknown SBPTR gives a miss and allocates nothing.
- Fill, SBPTR present: an existing entry with the same ctx and vpn is overwritten in place. Otherwise the lowest-index invalid entry is used. If no entry is invalid, the entry at the RR pointer is replaced and the pointer increments mod ENTRIES (wraps ENTRIES-1 -> 0).
- Fill, SBPTR absent: allocate the lowest free context slot. If all slots are used, evict the slot at the ctx RR pointer: clear all entries tagged with that slot, raise inval_valid with the evicted sbptr, and increment the ctx RR pointer. The entry is then installed the same cycle.
- Create, SBPTR present: clear all entries of that slot and keep the slot. Raise inval_valid with create_sbptr.
- Create, SBPTR absent: allocate a slot as for fill; an eviction notifies the evicted sbptr. A free-slot allocation raises no notify.
- Notify holds inval_valid and inval_sbptr until inval_retry=0. At most one notify is pending at a time.
- A lookup in the cycle after a flush, fill or create sees the updated array state.
- Reset mid-operation clears everything, including a pending notify and response.

Test Plan:
- After reset: fill (sbptr=0x010, vpn=0x5, ppn=0x99), then lookup (0x010, 0x5) -> next cycle resp_valid=1, resp_hit=1, resp_ppn=0x99.
- Lookup vpn=0x6 or sbptr=0x011 -> resp_hit=0, resp_ppn=0. With resp_retry=1 for 3 cycles, the response is held and lookup_retry=1.
- Fill 17 distinct vpns in one ctx with ENTRIES=16 -> the 17th replaces entry 0, so vpn #1 misses and vpn #17 hits. The next overflow replaces entry 1.
- Fill 5 distinct sbptrs with NUM_CTX=4 -> inval_valid=1 with inval_sbptr = 1st sbptr. Its vpns miss; the 5th context hits.
- create_sbptr=0x010 with an existing ctx -> all 0x010 entries miss and inval_sbptr=0x010. With inval_retry=1, a second create sees create_retry=1 until the notify drains.
- Create, fill and lookup valid in the same cycle -> only create is accepted; fill_retry=1 and lookup_retry=1.
